// File: rtl/sr_write_queue_pkg.sv
// Shared sizes and SR indices for the special-register write path.
// SR_WQ_DEPTH is the default queue depth used by sr_write_queue.
package sr_write_queue_pkg;

  localparam int HBIT_TGT_GP = 3;
  localparam int SIZE_ADDR   = 48;
  localparam int HBIT_ADDR   = SIZE_ADDR - 1;
  localparam int HBIT_SR     = 15;

  localparam logic [HBIT_TGT_GP:0] SR_IDX_SSP = 4'd6;

  localparam int SR_WQ_DEPTH = 4;

endpackage

// File: rtl/sr_fwd_match.sv
// Youngest-match forwarding mux for one SR read port: scans queued entries
// from head (oldest) to tail (youngest); the last hit wins, else raw SR data.
module sr_fwd_match
  import sr_write_queue_pkg::*;
#(
  parameter  int DEPTH = SR_WQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic [DEPTH-1:0][HBIT_TGT_GP:0] entry_addr,
  input  logic [DEPTH-1:0][HBIT_ADDR:0]   entry_data,
  input  logic [PTR_W-1:0]                head,
  input  logic [CNT_W-1:0]                count,
  input  logic [HBIT_TGT_GP:0]            read_addr,
  input  logic [HBIT_ADDR:0]              sr_data,
  output logic [HBIT_ADDR:0]              read_data
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    read_data = sr_data;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entry_addr[idx] == read_addr)) begin
        read_data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/sr_write_queue.sv
// In-order SR write queue: trap/execute sources, one drain per cycle, read forwarding.
// Optional SR_WQ_COALESCE_EN: a write to the same SR as the tail merges into the tail entry.
module sr_write_queue
  import sr_write_queue_pkg::*;
#(
  parameter  int DEPTH = SR_WQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  input  logic                   iw_trap_valid,
  output logic                   ow_trap_ready,
  input  logic [HBIT_TGT_GP:0]   iw_trap_addr,
  input  logic [HBIT_ADDR:0]     iw_trap_data,
  input  logic                   iw_ex_valid,
  output logic                   ow_ex_ready,
  input  logic [HBIT_TGT_GP:0]   iw_ex_addr,
  input  logic [HBIT_ADDR:0]     iw_ex_data,
  input  logic                   iw_drain_hold,
  output logic [HBIT_TGT_GP:0]   ow_write_addr,
  output logic [HBIT_ADDR:0]     ow_write_data,
  output logic                   ow_write_enable,
  input  logic [HBIT_TGT_GP:0]   iw_read_addr1,
  input  logic [HBIT_TGT_GP:0]   iw_read_addr2,
  input  logic [HBIT_ADDR:0]     iw_sr_data1,
  input  logic [HBIT_ADDR:0]     iw_sr_data2,
  output logic [HBIT_ADDR:0]     ow_read_data1,
  output logic [HBIT_ADDR:0]     ow_read_data2,
  output logic [CNT_W-1:0]       ow_count,
  output logic                   ow_empty
);

  // Handshake: a source transfers on the posedge where valid && ready are both high.
  // Ready depends only on the registered count (a same-cycle drain is not credited).

  logic [DEPTH-1:0][HBIT_TGT_GP:0] addr_q;
  logic [DEPTH-1:0][HBIT_ADDR:0]   data_q;
  logic [PTR_W-1:0]                head_q, tail_q, tail_last;
  logic [CNT_W-1:0]                count_q;

  logic                 full, not_empty, drain;
  logic                 trap_acc, ex_acc, enq, alloc, coalesce;
  logic [HBIT_TGT_GP:0] enq_addr;
  logic [HBIT_ADDR:0]   enq_data;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign not_empty = (count_q != '0);
  assign drain     = not_empty && !iw_drain_hold;
  assign tail_last = tail_q - PTR_W'(1);

  assign ow_trap_ready = !full;
  assign ow_ex_ready   = !iw_trap_valid && !full;

  assign trap_acc = iw_trap_valid && ow_trap_ready;
  assign ex_acc   = iw_ex_valid && ow_ex_ready;
  assign enq      = trap_acc || ex_acc;
  assign enq_addr = trap_acc ? iw_trap_addr : iw_ex_addr;
  assign enq_data = trap_acc ? iw_trap_data : iw_ex_data;

`ifdef SR_WQ_COALESCE_EN
  // With one entry draining this cycle the tail is the head; never merge into it.
  assign coalesce = enq && not_empty && (addr_q[tail_last] == enq_addr) &&
                    !(drain && (count_q == CNT_W'(1)));
`else
  assign coalesce = 1'b0;
`endif
  assign alloc = enq && !coalesce;

  always_ff @(posedge iw_clk) begin
    if (alloc) begin
      addr_q[tail_q] <= enq_addr;
      data_q[tail_q] <= enq_data;
    end else if (coalesce) begin
      data_q[tail_last] <= enq_data;
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc) tail_q <= tail_q + PTR_W'(1);
      if (drain) head_q <= head_q + PTR_W'(1);
      case ({alloc, drain})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign ow_write_enable = drain;
  assign ow_write_addr   = not_empty ? addr_q[head_q] : '0;
  assign ow_write_data   = not_empty ? data_q[head_q] : '0;
  assign ow_count        = count_q;
  assign ow_empty        = !not_empty;

  sr_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entry_addr (addr_q),
    .entry_data (data_q),
    .head       (head_q),
    .count      (count_q),
    .read_addr  (iw_read_addr1),
    .sr_data    (iw_sr_data1),
    .read_data  (ow_read_data1)
  );

  sr_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entry_addr (addr_q),
    .entry_data (data_q),
    .head       (head_q),
    .count      (count_q),
    .read_addr  (iw_read_addr2),
    .sr_data    (iw_sr_data2),
    .read_data  (ow_read_data2)
  );

endmodule

// File: tb/tb_sr_write_queue.sv
// Scoreboard bench for sr_write_queue: accepted writes are queued as expected
// SR-file writes and a negedge monitor checks every ow_write_enable beat.
module tb_sr_write_queue;
  import sr_write_queue_pkg::*;

  localparam int AW = HBIT_TGT_GP + 1;
  localparam int DW = HBIT_ADDR + 1;

  logic          clk, rst;
  logic          trap_valid, trap_ready, ex_valid, ex_ready, drain_hold;
  logic [AW-1:0] trap_addr, ex_addr, write_addr, read_addr1, read_addr2;
  logic [DW-1:0] trap_data, ex_data, write_data, sr_data1, sr_data2;
  logic [DW-1:0] read_data1, read_data2;
  logic          write_enable, empty;
  logic [2:0]    count;

  logic [AW+DW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  sr_write_queue #(.DEPTH(4)) dut (
    .iw_clk(clk), .iw_rst(rst),
    .iw_trap_valid(trap_valid), .ow_trap_ready(trap_ready),
    .iw_trap_addr(trap_addr), .iw_trap_data(trap_data),
    .iw_ex_valid(ex_valid), .ow_ex_ready(ex_ready),
    .iw_ex_addr(ex_addr), .iw_ex_data(ex_data),
    .iw_drain_hold(drain_hold),
    .ow_write_addr(write_addr), .ow_write_data(write_data),
    .ow_write_enable(write_enable),
    .iw_read_addr1(read_addr1), .iw_read_addr2(read_addr2),
    .iw_sr_data1(sr_data1), .iw_sr_data2(sr_data2),
    .ow_read_data1(read_data1), .ow_read_data2(read_data2),
    .ow_count(count), .ow_empty(empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every SR-file write must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && write_enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sr_write: unexpected write addr=%0h data=%0h", write_addr, write_data);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({write_addr, write_data} !== e) begin
          failures++;
          $display("FAIL sr_write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   write_addr, write_data, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // driver: one ex request for one cycle; returns at posedge+1
  task automatic ex_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic exp_rdy);
    logic acc;
    ex_valid = 1'b1; ex_addr = a; ex_data = d;
    @(negedge clk);
    acc = ex_ready;
    check("ex_ready", 64'(ex_ready), 64'(exp_rdy));
    @(posedge clk);
    #1 ex_valid = 1'b0;
    if (acc) exp_q.push_back({a, d});
  endtask

  task automatic wait_empty();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (empty && exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_empty: count=%0d pending=%0d expected 0", count, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    trap_valid = 0; trap_addr = '0; trap_data = '0;
    ex_valid = 0; ex_addr = '0; ex_data = '0;
    drain_hold = 0;
    read_addr1 = '0; read_addr2 = '0; sr_data1 = '0; sr_data2 = '0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_we", 64'(write_enable), 64'd0);
    check("rst_waddr", 64'(write_addr), 64'd0);
    check("rst_wdata", 64'(write_data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset mid-drain with 3 entries
    drain_hold = 1;
    ex_write(4'd1, 48'h101, 1'b1);
    ex_write(4'd2, 48'h102, 1'b1);
    ex_write(4'd3, 48'h103, 1'b1);
    check("t1_count3", 64'(count), 64'd3);
    drain_hold = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("t1_count", 64'(count), 64'd0);
    check("t1_we", 64'(write_enable), 64'd0);
    check("t1_empty", 64'(empty), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("t1_count_after", 64'(count), 64'd0);

    // 2: single write, forwarding from the acceptance edge
    read_addr1 = SR_IDX_SSP; sr_data1 = 48'h1234;
    ex_valid = 1; ex_addr = SR_IDX_SSP; ex_data = 48'h0000_0000_0FF8;
    @(negedge clk);
    check("t2_ready", 64'(ex_ready), 64'd1);
    check("t2_nofwd_same_cycle", 64'(read_data1), 64'h1234);
    @(posedge clk);
    #1 ex_valid = 0;
    exp_q.push_back({SR_IDX_SSP, 48'h0000_0000_0FF8});
    @(negedge clk);
    check("t2_we", 64'(write_enable), 64'd1);
    check("t2_fwd", 64'(read_data1), 64'h0FF8);
    check("t2_count", 64'(count), 64'd1);
    @(posedge clk);
    #1;
    wait_empty();

    // 3: trap has priority over ex in the same cycle
    trap_valid = 1; trap_addr = 4'd2; trap_data = 48'd5;
    ex_valid = 1; ex_addr = 4'd3; ex_data = 48'd7;
    @(negedge clk);
    check("t3_ex_ready", 64'(ex_ready), 64'd0);
    check("t3_trap_ready", 64'(trap_ready), 64'd1);
    @(posedge clk);
    #1 trap_valid = 0;
    exp_q.push_back({4'd2, 48'd5});
    @(negedge clk);
    check("t3_ex_ready2", 64'(ex_ready), 64'd1);
    @(posedge clk);
    #1 ex_valid = 0;
    exp_q.push_back({4'd3, 48'd7});
    wait_empty();

    // 4: fill to DEPTH under hold, then release
    drain_hold = 1;
    for (int i = 0; i < 4; i++) ex_write(AW'(8 + i), DW'(48'hA0 + i), 1'b1);
    ex_valid = 1; ex_addr = 4'd12; ex_data = 48'hA4;
    @(negedge clk);
    check("t4_ex_ready_full", 64'(ex_ready), 64'd0);
    check("t4_trap_ready_full", 64'(trap_ready), 64'd0);
    check("t4_count", 64'(count), 64'd4);
    check("t4_we_hold", 64'(write_enable), 64'd0);
    @(posedge clk);
    #1 drain_hold = 0;
    @(negedge clk);
    check("t4_ready_ignores_drain", 64'(ex_ready), 64'd0);
    begin
      bit got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        got = ex_ready;
        @(posedge clk);
        #1;
      end
      ex_valid = 0;
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL t4_fifth_accept: got 0 expected 1");
      end else exp_q.push_back({4'd12, 48'hA4});
    end
    wait_empty();

    // 5: youngest-match forwarding
    drain_hold = 1;
    read_addr1 = 4'd1; sr_data1 = '0;
    read_addr2 = 4'd9; sr_data2 = 48'hABC;
    ex_write(4'd1, 48'd10, 1'b1);
    #1 check("t5_fwd_first", 64'(read_data1), 64'd10);
    ex_write(4'd1, 48'd20, 1'b1);
`ifdef SR_WQ_COALESCE_EN
    exp_q.delete(exp_q.size() - 2);
`endif
    #1;
    check("t5_fwd_youngest", 64'(read_data1), 64'd20);
    check("t5_passthru", 64'(read_data2), 64'hABC);
    drain_hold = 0;
    wait_empty();

    // 6: same-address pair under hold (merged only with coalescing)
    drain_hold = 1;
    ex_write(4'd4, 48'd1, 1'b1);
    ex_write(4'd4, 48'd2, 1'b1);
`ifdef SR_WQ_COALESCE_EN
    exp_q.delete(exp_q.size() - 2);
    check("t6_count", 64'(count), 64'd1);
`else
    check("t6_count", 64'(count), 64'd2);
`endif
    drain_hold = 0;
    wait_empty();

    check("final_pending", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
